// File: rtl/rv32i_pkg.sv
// Shared RV32I pipeline constants and types.
// Used by hazard control, forwarding and decode.
package rv32i_pkg;

    localparam logic [1:0] M2R_ALU = 2'b00;
    localparam logic [1:0] M2R_MEM = 2'b01;
    localparam logic [1:0] M2R_PC4 = 2'b10;

    localparam logic [0:0] ST_RUN      = 1'b0;
    localparam logic [0:0] ST_MEM_WAIT = 1'b1;

    typedef struct packed {
        logic pc_write;
        logic if_id_write;
        logic id_exe_write;
        logic ex_mem_write;
        logic if_id_flush;
        logic id_exe_flush;
        logic mem_wb_flush;
    } hz_ctl_t;

    localparam hz_ctl_t CTL_IDLE = 7'b0000_000;
    localparam hz_ctl_t CTL_RUN  = 7'b1111_000;
    localparam hz_ctl_t CTL_FRZ  = 7'b0000_001;
    localparam hz_ctl_t CTL_RDR  = 7'b1111_110;
    localparam hz_ctl_t CTL_LU   = 7'b0011_010;

    function automatic logic src_hit(
        input logic       used,
        input logic [4:0] rs,
        input logic [4:0] rd
    );
        return used && (rs == rd);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear.
// Clear wins over increment; holds at all-ones.
module sat_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    logic at_max;

    assign at_max = &count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && !at_max) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/hazard_stall_controller.sv
// Stall/flush control for load-use, dmem wait and redirects.
// Also tracks dmem timeout and a saturating stall counter.
module hazard_stall_controller
    import rv32i_pkg::*;
#(
    parameter int MEM_TIMEOUT = 64,
    parameter int STALL_CNT_W = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [4:0]             reg_file_read_address_0_IF_ID,
    input  logic [4:0]             reg_file_read_address_1_IF_ID,
    input  logic                   use_rs1_IF_ID,
    input  logic                   use_rs2_IF_ID,
    input  logic                   reg_file_write_ID_EXE,
    input  logic [4:0]             reg_file_write_address_ID_EXE,
    input  logic [1:0]             mux_0_sel_ID_EXE,
    input  logic                   branch_taken_EXE,
    input  logic                   dmem_req_EX_MEM,
    input  logic                   dmem_ready,
    input  logic                   stall_cnt_clr,
    output logic                   pc_write,
    output logic                   if_id_write,
    output logic                   id_exe_write,
    output logic                   ex_mem_write,
    output logic                   if_id_flush,
    output logic                   id_exe_flush,
    output logic                   mem_wb_flush,
    output logic                   mem_timeout,
    output logic [STALL_CNT_W-1:0] stall_count
);

    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

    logic [0:0]        state;
    logic [0:0]        state_nxt;
    logic [WAIT_W-1:0] wait_cnt;
    logic              wait_clr;
    logic              wait_inc;
    logic              load_use;
    logic              mem_stall;
    logic              freeze;
    logic              redirect;
    logic              lu_stall;
    logic              rd_nz;
    logic              rd_mem;
    hz_ctl_t           ctl_raw;
    hz_ctl_t           ctl;

    assign rd_nz  = reg_file_write_address_ID_EXE != 5'd0;
    assign rd_mem = mux_0_sel_ID_EXE == M2R_MEM;

    assign load_use = reg_file_write_ID_EXE && rd_mem && rd_nz &&
        (src_hit(use_rs1_IF_ID, reg_file_read_address_0_IF_ID,
                 reg_file_write_address_ID_EXE) ||
         src_hit(use_rs2_IF_ID, reg_file_read_address_1_IF_ID,
                 reg_file_write_address_ID_EXE));

    assign mem_stall = dmem_req_EX_MEM && !dmem_ready;

    // Mutually exclusive so the decoder below can be unique.
    assign freeze   = mem_stall;
    assign redirect = branch_taken_EXE && !freeze;
    assign lu_stall = load_use && !freeze && !branch_taken_EXE;

    always_comb begin
        ctl_raw = CTL_RUN;
        unique case (1'b1)
            freeze:   ctl_raw = CTL_FRZ;
            redirect: ctl_raw = CTL_RDR;
            lu_stall: ctl_raw = CTL_LU;
            default:  ctl_raw = CTL_RUN;
        endcase
    end

    assign ctl = rst_n ? ctl_raw : CTL_IDLE;

    assign pc_write     = ctl.pc_write;
    assign if_id_write  = ctl.if_id_write;
    assign id_exe_write = ctl.id_exe_write;
    assign ex_mem_write = ctl.ex_mem_write;
    assign if_id_flush  = ctl.if_id_flush;
    assign id_exe_flush = ctl.id_exe_flush;
    assign mem_wb_flush = ctl.mem_wb_flush;

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_RUN:      state_nxt = mem_stall ? ST_MEM_WAIT : ST_RUN;
            ST_MEM_WAIT: state_nxt = dmem_ready ? ST_RUN : ST_MEM_WAIT;
            default:     state_nxt = ST_RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_RUN;
        end else begin
            state <= state_nxt;
        end
    end

    assign wait_clr = (state == ST_RUN) && mem_stall;
    assign wait_inc = state == ST_MEM_WAIT;

    sat_counter #(
        .WIDTH(WAIT_W)
    ) u_wait_cnt (
        .clk  (clk),
        .rst_n(rst_n),
        .clr  (wait_clr),
        .inc  (wait_inc),
        .count(wait_cnt)
    );

    // Raised on the edge where wait_cnt reaches MEM_TIMEOUT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_timeout <= 1'b0;
        end else if (wait_inc && (wait_cnt >= WAIT_LAST)) begin
            mem_timeout <= 1'b1;
        end
    end

    sat_counter #(
        .WIDTH(STALL_CNT_W)
    ) u_stall_cnt (
        .clk  (clk),
        .rst_n(rst_n),
        .clr  (stall_cnt_clr),
        .inc  (!pc_write),
        .count(stall_count)
    );

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Self-checking bench for hazard_stall_controller.
// Table vectors plus scoreboarded multi-cycle sequences.
module tb_hazard_stall_controller;

    localparam logic [6:0] E_IDLE = 7'b0000_000;
    localparam logic [6:0] E_NRM  = 7'b1111_000;
    localparam logic [6:0] E_FRZ  = 7'b0000_001;
    localparam logic [6:0] E_RDR  = 7'b1111_110;
    localparam logic [6:0] E_LU   = 7'b0011_010;

    typedef struct {
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       u1;
        logic       u2;
        logic       wr;
        logic [4:0] rd;
        logic [1:0] sel;
        logic       br;
        logic       req;
        logic       rdy;
        logic [6:0] exp;
        string      tag;
    } vec_t;

    typedef struct {
        logic [6:0] exp;
        string      tag;
    } sb_t;

    logic       clk;
    logic       rst_n;
    logic [4:0] rs1, rs2, rd;
    logic       u1, u2, wr, br, req, rdy, clr;
    logic [1:0] sel;
    logic       pc_write, if_id_write, id_exe_write, ex_mem_write;
    logic       if_id_flush, id_exe_flush, mem_wb_flush;
    logic       mem_timeout;
    logic [3:0] stall_count;
    logic [6:0] ctl;

    int checks;
    int failures;
    vec_t tbl[12];
    sb_t  sb[$];

    hazard_stall_controller #(
        .MEM_TIMEOUT(4),
        .STALL_CNT_W(4)
    ) dut (
        .clk                          (clk),
        .rst_n                        (rst_n),
        .reg_file_read_address_0_IF_ID(rs1),
        .reg_file_read_address_1_IF_ID(rs2),
        .use_rs1_IF_ID                (u1),
        .use_rs2_IF_ID                (u2),
        .reg_file_write_ID_EXE        (wr),
        .reg_file_write_address_ID_EXE(rd),
        .mux_0_sel_ID_EXE             (sel),
        .branch_taken_EXE             (br),
        .dmem_req_EX_MEM              (req),
        .dmem_ready                   (rdy),
        .stall_cnt_clr                (clr),
        .pc_write                     (pc_write),
        .if_id_write                  (if_id_write),
        .id_exe_write                 (id_exe_write),
        .ex_mem_write                 (ex_mem_write),
        .if_id_flush                  (if_id_flush),
        .id_exe_flush                 (id_exe_flush),
        .mem_wb_flush                 (mem_wb_flush),
        .mem_timeout                  (mem_timeout),
        .stall_count                  (stall_count)
    );

    assign ctl = {pc_write, if_id_write, id_exe_write, ex_mem_write,
                  if_id_flush, id_exe_flush, mem_wb_flush};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(
        input logic [4:0] a, input logic [4:0] b,
        input logic p, input logic q, input logic w,
        input logic [4:0] d, input logic [1:0] s,
        input logic bt, input logic rq, input logic ry,
        input logic [6:0] e, input string t
    );
        vec_t v;
        v.rs1 = a; v.rs2 = b; v.u1 = p; v.u2 = q; v.wr = w;
        v.rd = d; v.sel = s; v.br = bt; v.req = rq; v.rdy = ry;
        v.exp = e; v.tag = t;
        return v;
    endfunction

    task automatic chk(input string t, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h want %0h", t, act, exp);
        end
    endtask

    task automatic apply(input vec_t v);
        sb_t e;
        rs1 = v.rs1; rs2 = v.rs2; u1 = v.u1; u2 = v.u2; wr = v.wr;
        rd = v.rd; sel = v.sel; br = v.br; req = v.req; rdy = v.rdy;
        e.exp = v.exp;
        e.tag = v.tag;
        sb.push_back(e);
    endtask

    task automatic observe();
        sb_t e;
        @(negedge clk);
        if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL sb_empty: got 0 want 1");
        end else begin
            e = sb.pop_front();
            chk(e.tag, 32'(ctl), 32'(e.exp));
        end
        @(posedge clk);
        #1;
    endtask

    task automatic step(input vec_t v);
        apply(v);
        observe();
    endtask

    task automatic idle_in();
        rs1 = 0; rs2 = 0; u1 = 0; u2 = 0; wr = 0; rd = 0;
        sel = 0; br = 0; req = 0; rdy = 0; clr = 0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle_in();
        #1;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    vec_t lu_v, nrm_v, frz_v, rdy_v, frzb_v, rdyb_v;

    initial begin
        checks = 0;
        failures = 0;
        rst_n = 1'b0;
        idle_in();

        tbl[0]  = mk(1, 5, 1, 1, 1, 5, 2'b01, 0, 0, 0, E_LU,  "lu_rs2");
        tbl[1]  = mk(1, 0, 1, 1, 1, 0, 2'b01, 0, 0, 0, E_NRM, "lu_rd0");
        tbl[2]  = mk(1, 5, 1, 1, 1, 5, 2'b00, 0, 0, 0, E_NRM, "lu_alu");
        tbl[3]  = mk(1, 5, 1, 0, 1, 5, 2'b01, 0, 0, 0, E_NRM, "lu_nouse");
        tbl[4]  = mk(7, 2, 1, 1, 1, 7, 2'b01, 0, 0, 0, E_LU,  "lu_rs1");
        tbl[5]  = mk(7, 2, 1, 1, 0, 7, 2'b01, 0, 0, 0, E_NRM, "lu_nowr");
        tbl[6]  = mk(1, 5, 1, 1, 1, 5, 2'b01, 1, 0, 0, E_RDR, "br_lu");
        tbl[7]  = mk(1, 2, 1, 1, 0, 0, 2'b00, 1, 0, 0, E_RDR, "br_only");
        tbl[8]  = mk(1, 5, 1, 1, 1, 5, 2'b10, 0, 0, 0, E_NRM, "lu_pc4");
        tbl[9]  = mk(1, 5, 1, 1, 1, 5, 2'b01, 1, 1, 0, E_FRZ, "frz_all");
        tbl[10] = mk(1, 5, 1, 1, 1, 5, 2'b01, 0, 1, 1, E_LU,  "rdy_lu");
        tbl[11] = mk(1, 2, 1, 1, 0, 0, 2'b00, 0, 0, 0, E_NRM, "idle");

        lu_v   = tbl[0];
        nrm_v  = tbl[11];
        frz_v  = mk(0, 0, 0, 0, 0, 0, 2'b00, 0, 1, 0, E_FRZ, "mw_frz");
        rdy_v  = mk(0, 0, 0, 0, 0, 0, 2'b00, 0, 1, 1, E_NRM, "mw_rdy");
        frzb_v = mk(0, 0, 0, 0, 0, 0, 2'b00, 1, 1, 0, E_FRZ, "frz_br");
        rdyb_v = mk(0, 0, 0, 0, 0, 0, 2'b00, 1, 1, 1, E_RDR, "rdy_br");

        // reset state, with a stalling input pattern applied
        rs2 = 5; u2 = 1; wr = 1; rd = 5; sel = 2'b01; req = 1;
        #1;
        chk("rst_ctl", 32'(ctl), 32'(E_IDLE));
        chk("rst_cnt", 32'(stall_count), 0);
        chk("rst_to", 32'(mem_timeout), 0);
        do_reset();

        for (int i = 0; i < 12; i++) step(tbl[i]);
        chk("tbl_cnt", 32'(stall_count), 4);

        // single load-use bubble
        do_reset();
        step(lu_v);
        nrm_v.tag = "lu_after";
        step(nrm_v);
        chk("lu_cnt", 32'(stall_count), 1);

        // 3-cycle memory wait then advance
        do_reset();
        for (int i = 0; i < 3; i++) step(frz_v);
        step(rdy_v);
        chk("mw_cnt", 32'(stall_count), 3);
        chk("mw_to", 32'(mem_timeout), 0);

        // back-to-back access restarts wait_cnt; then timeout
        for (int i = 0; i < 4; i++) step(frz_v);
        chk("to_early", 32'(mem_timeout), 0);
        step(frz_v);
        chk("to_rise", 32'(mem_timeout), 1);

        // branch held through freeze acts after ready
        step(frzb_v);
        step(rdyb_v);
        nrm_v.tag = "post_br";
        step(nrm_v);
        chk("to_sticky", 32'(mem_timeout), 1);
        chk("b2b_cnt", 32'(stall_count), 9);

        // async reset in the middle of MEM_WAIT
        step(frz_v);
        step(frz_v);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_ctl", 32'(ctl), 32'(E_IDLE));
        chk("arst_to", 32'(mem_timeout), 0);
        chk("arst_cnt", 32'(stall_count), 0);
        @(negedge clk);
        idle_in();
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        nrm_v.tag = "arst_run";
        step(nrm_v);
        step(rdy_v);

        // saturation at 15, then clear beats increment
        do_reset();
        for (int i = 0; i < 20; i++) step(lu_v);
        chk("sat_cnt", 32'(stall_count), 15);
        clr = 1'b1;
        lu_v.tag = "clr_lu";
        step(lu_v);
        chk("clr_cnt", 32'(stall_count), 0);
        clr = 1'b0;
        step(nrm_v);
        chk("clr_hold", 32'(stall_count), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
